uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the clock/baud figures and the default timing parameters.
package uart_pkg;

    localparam int CLK_FREQ        = 100_000_000;
    localparam int BAUD            = 9600;
    localparam int TIMEOUT_CYC_DEF = 131072;
    localparam int GAP_CYC_DEF     = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_e;

    function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector, purely combinational: first asserted request at or after i_ptr.
// Zero latency; o_valid is low when no request is present.
module rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic               o_valid,
    output logic [1:0]         o_idx
);

    logic [3:0] w_req_pad;
    logic [2:0] w_sum;
    logic [1:0] w_j;

    assign w_req_pad = 4'(i_req);

    // Walk from the farthest candidate back to i_ptr so the nearest hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_ptr;
        w_sum   = '0;
        w_j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = 3'(i_ptr) + 3'(k);
            w_j   = (w_sum >= 3'(NUM_REQ)) ? 2'(w_sum - 3'(NUM_REQ)) : w_sum[1:0];
            if (w_req_pad[w_j]) begin
                o_valid = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter; tx_start/ack fire in the cycle after a request is seen in IDLE.
// Requests wait (no ack) while a frame, its completion timeout or the post-frame gap is in progress.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_busy,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic [1:0]             o_grant_id,
    output logic                   o_timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    arb_state_e      r_state;
    arb_state_e      w_next;
    logic [1:0]      r_ptr;
    logic [1:0]      r_grant;
    logic [7:0]      r_tx_data;
    logic [TW-1:0]   r_to_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_timeout_err;

    logic            w_pick_vld;
    logic [1:0]      w_pick_idx;
    logic [7:0]      w_pick_byte;
    logic            w_waiting;
    logic            w_to_hit;
    logic            w_gap_end;
    logic            w_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == 2'(i)) begin
                w_pick_byte = i_req_data[8*i +: 8];
            end
        end
    end

    assign w_waiting = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
    // A tx_done landing on the last allowed cycle still counts as a clean finish.
    assign w_to_hit  = w_waiting && !i_tx_done && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_gap_end = (r_gap_cnt == GW'(GAP_CYC - 1));
    assign w_grant   = (r_state == ST_IDLE) && w_pick_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_done || w_to_hit) w_next = ST_GAP;
                else if (i_tx_busy)        w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_tx_done || w_to_hit) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_end) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_tx_start = (r_state == ST_ISSUE);
        o_ack      = (r_state == ST_ISSUE) ? NUM_REQ'(idx_onehot(r_grant)) : '0;
        o_busy     = (r_state != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr         <= '0;
            r_grant       <= '0;
            r_tx_data     <= '0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_to_hit;

            if (w_grant) begin
                r_grant   <= w_pick_idx;
                r_tx_data <= w_pick_byte;
                r_ptr     <= (w_pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : w_pick_idx + 2'd1;
            end

            if (r_state == ST_ISSUE) begin
                r_to_cnt <= '0;
            end else if (w_waiting) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (r_state == ST_GAP && !w_gap_end) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_grant_id    = r_grant;
    assign o_timeout_err = r_timeout_err;

endmodule
